// File: rtl/logic_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : logic_unit_pkg                                             |
// | Purpose : Shared op codes and FSM state encoding for the sliced      |
// |           bitwise logic unit (bitwise_logic_seq / bitwise_slice).    |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package logic_unit_pkg;

   // Operation select codes
   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOR = 2'b11;

   // Controller state encoding
   localparam int         STATE_W = 2;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage : logic_unit_pkg
`default_nettype wire

// File: rtl/bitwise_slice.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bitwise_slice                                              |
// | Purpose : Combinational SLICE-wide AND/OR/XOR/NOR selected by op.    |
// | Ports   : op [1:0] operation code                                    |
// |           a  [SLICE-1:0] operand A slice                             |
// |           b  [SLICE-1:0] operand B slice                             |
// |           y  [SLICE-1:0] slice result                                |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module bitwise_slice
   import logic_unit_pkg::*;
#(
   parameter int SLICE = 8
) (
   input  logic [1:0]       op,
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   output logic [SLICE-1:0] y
);

   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NOR:  y = ~(a | b);
         default: y = '0;
      endcase
   end

endmodule : bitwise_slice
`default_nettype wire

// File: rtl/bitwise_logic_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bitwise_logic_seq                                          |
// | Purpose : Multi-cycle bitwise logic unit. Captures two WIDTH-bit     |
// |           operands and an op, then evaluates SLICE bits per clock    |
// |           through a single shared slice engine, accumulating parity  |
// |           and zero flags alongside the result.                       |
// | Ports   : clk, rst (sync, active-high)                               |
// |           in_valid/in_ready   operation handshake                    |
// |           op[1:0], a, b       operation and operands                 |
// |           out_valid/out_ready result handshake                       |
// |           result, parity, zero                                       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module bitwise_logic_seq
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             parity,
   output logic             zero
);

   localparam int             NSLICE = WIDTH / SLICE;
   localparam int             CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NSLICE - 1);

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_next_state;

   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [1:0]         r_op;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_result;
   logic               r_parity;
   logic               r_zero;

   logic [SLICE-1:0]   w_a_slice;
   logic [SLICE-1:0]   w_b_slice;
   logic [SLICE-1:0]   w_slice_res;
   logic               w_accept;
   logic               w_release;
   logic               w_last;

   assign w_accept  = in_valid  && in_ready;
   assign w_release = out_valid && out_ready;
   assign w_last    = (r_cnt == C_LAST);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)  w_next_state = ST_RUN;
         ST_RUN:  if (w_last)    w_next_state = ST_DONE;
         ST_DONE: if (w_release) w_next_state = ST_IDLE;
         default:                w_next_state = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         ST_IDLE: in_ready  = 1'b1;
         ST_DONE: out_valid = 1'b1;
         default: ;
      endcase
   end

   // Select the operand slice addressed by the counter for the shared engine.
   always_comb begin
      w_a_slice = '0;
      w_b_slice = '0;
      for (int i = 0; i < NSLICE; i++) begin
         if (r_cnt == CNT_W'(i)) begin
            w_a_slice = r_a[i*SLICE +: SLICE];
            w_b_slice = r_b[i*SLICE +: SLICE];
         end
      end
   end

   bitwise_slice #(
      .SLICE (SLICE)
   ) u_slice (
      .op (r_op),
      .a  (w_a_slice),
      .b  (w_b_slice),
      .y  (w_slice_res)
   );

   // ---------------- Datapath: capture, counter, accumulators ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= OP_AND;
         r_cnt    <= '0;
         r_result <= '0;
         r_parity <= 1'b0;
         r_zero   <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_op     <= op;
                  r_cnt    <= '0;
                  r_result <= '0;
                  r_parity <= 1'b0;
                  r_zero   <= 1'b1;
               end
            end
            ST_RUN: begin
               for (int i = 0; i < NSLICE; i++) begin
                  if (r_cnt == CNT_W'(i)) begin
                     r_result[i*SLICE +: SLICE] <= w_slice_res;
                  end
               end
               r_parity <= r_parity ^ (^w_slice_res);
               r_zero   <= r_zero & (w_slice_res == '0);
               // Wrap explicitly so non-power-of-two slice counts stay in range.
               r_cnt    <= w_last ? '0 : r_cnt + CNT_W'(1);
            end
            default: ; // DONE holds result and flags stable
         endcase
      end
   end

   assign result = r_result;
   assign parity = r_parity;
   assign zero   = r_zero;

endmodule : bitwise_logic_seq
`default_nettype wire

// File: tb/tb_bitwise_logic_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_bitwise_logic_seq                                       |
// | Purpose : Directed self-checking bench for bitwise_logic_seq, with   |
// |           one 32/8 instance and one 32/32 (single slice) instance.   |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_bitwise_logic_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   // 32/8 instance
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  op = 2'b00;
   logic [31:0] a  = '0;
   logic [31:0] b  = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        parity;
   logic        zero;

   // 32/32 instance
   logic        in_valid_w = 1'b0;
   logic        in_ready_w;
   logic [1:0]  op_w = 2'b00;
   logic [31:0] a_w  = '0;
   logic [31:0] b_w  = '0;
   logic        out_valid_w;
   logic        out_ready_w = 1'b0;
   logic [31:0] result_w;
   logic        parity_w;
   logic        zero_w;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bitwise_logic_seq #(.WIDTH(32), .SLICE(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .parity    (parity),
      .zero      (zero)
   );

   bitwise_logic_seq #(.WIDTH(32), .SLICE(32)) dut_w (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_w),
      .in_ready  (in_ready_w),
      .op        (op_w),
      .a         (a_w),
      .b         (b_w),
      .out_valid (out_valid_w),
      .out_ready (out_ready_w),
      .result    (result_w),
      .parity    (parity_w),
      .zero      (zero_w)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one rising edge; land 1 time unit after it for sampling/driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full transaction on the 32/8 instance: accept, check latency, check
   // results, consume, check return to idle.
   task automatic run8(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp_res,
                       input logic exp_par, input logic exp_zero);
      op = o; a = x; b = y; in_valid = 1'b1;
      tick();                          // acceptance edge E0
      in_valid = 1'b0;
      a = ~x; b = ~y; op = ~o;         // must not affect the captured operation
      chk({tag, ".busy"}, {31'd0, in_ready}, 32'd0);
      for (int k = 1; k < 4; k++) begin
         tick();
         chk({tag, ".early_valid"}, {31'd0, out_valid}, 32'd0);
      end
      tick();                          // E0+4
      chk({tag, ".valid"},  {31'd0, out_valid}, 32'd1);
      chk({tag, ".result"}, result, exp_res);
      chk({tag, ".parity"}, {31'd0, parity}, {31'd0, exp_par});
      chk({tag, ".zero"},   {31'd0, zero},   {31'd0, exp_zero});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, ".drop"},   {31'd0, out_valid}, 32'd0);
      chk({tag, ".ready"},  {31'd0, in_ready},  32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- reset ----------------
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("rst.in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst.result",    result,             32'd0);
      chk("rst.parity",    {31'd0, parity},    32'd0);
      chk("rst.zero",      {31'd0, zero},      32'd1);
      chk("rst_w.in_ready", {31'd0, in_ready_w}, 32'd1);

      // ---------------- directed operations ----------------
      run8("xor", 2'b10, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0);
      run8("and", 2'b00, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
      run8("nor", 2'b11, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 1'b0);
      run8("or",  2'b01, 32'h0000_00F0, 32'h0000_0F0F, 32'h0000_0FFF, 1'b0, 1'b0);

      // ---------------- backpressure ----------------
      op = 2'b01; a = 32'h0000_00FF; b = 32'h0000_0100; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk("bp.valid", {31'd0, out_valid}, 32'd1);
      for (int k = 0; k < 10; k++) begin
         in_valid = k[0];
         op = 2'b10; a = 32'hDEAD_BEEF + k; b = 32'h1234_0000;
         tick();
         chk("bp.hold_valid",  {31'd0, out_valid}, 32'd1);
         chk("bp.hold_ready",  {31'd0, in_ready},  32'd0);
         chk("bp.hold_result", result,             32'h0000_01FF);
         chk("bp.hold_parity", {31'd0, parity},    32'd1);
         chk("bp.hold_zero",   {31'd0, zero},      32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp.consumed", {31'd0, out_valid}, 32'd0);
      chk("bp.idle",     {31'd0, in_ready},  32'd1);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("bp.no_repeat", {31'd0, out_valid}, 32'd0);
      end

      // ---------------- reset mid-RUN ----------------
      op = 2'b10; a = 32'hFFFF_FFFF; b = 32'h0000_0000; in_valid = 1'b1;
      tick();                          // E0
      in_valid = 1'b0;
      tick();                          // E0+1
      rst = 1'b1;
      tick();                          // E0+2: reset
      rst = 1'b0;
      chk("rr.out_valid", {31'd0, out_valid}, 32'd0);
      chk("rr.result",    result,             32'd0);
      chk("rr.parity",    {31'd0, parity},    32'd0);
      chk("rr.zero",      {31'd0, zero},      32'd1);
      chk("rr.in_ready",  {31'd0, in_ready},  32'd1);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("rr.stay_low", {31'd0, out_valid}, 32'd0);
      end
      run8("rr.after", 2'b00, 32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_0001, 1'b0, 1'b0);

      // ---------------- reset in DONE ----------------
      op = 2'b01; a = 32'h0000_0003; b = 32'h0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk("rd.valid", {31'd0, out_valid}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rd.out_valid", {31'd0, out_valid}, 32'd0);
      chk("rd.result",    result,             32'd0);
      chk("rd.zero",      {31'd0, zero},      32'd1);

      // ---------------- reset and in_valid on the same edge ----------------
      op = 2'b10; a = 32'h1; b = 32'h0; in_valid = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      tick();
      chk("rv.in_ready", {31'd0, in_ready}, 32'd1);
      chk("rv.result",   result,            32'd0);

      // ---------------- single-slice instance ----------------
      op_w = 2'b01; a_w = 32'hA000_0005; b_w = 32'h0A00_0050; in_valid_w = 1'b1;
      tick();
      in_valid_w = 1'b0;
      chk("w.in_ready", {31'd0, in_ready_w}, 32'd0);
      tick();
      chk("w.valid",  {31'd0, out_valid_w}, 32'd1);
      chk("w.result", result_w,             32'hAA00_0055);
      chk("w.parity", {31'd0, parity_w},    32'd0);
      chk("w.zero",   {31'd0, zero_w},      32'd0);
      out_ready_w = 1'b1;
      tick();
      out_ready_w = 1'b0;
      chk("w.drop",  {31'd0, out_valid_w}, 32'd0);
      chk("w.ready", {31'd0, in_ready_w},  32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_bitwise_logic_seq
`default_nettype wire
